// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA channel cycle sequencer.
package dma_pkg;

  typedef enum logic [2:0] {
    SI,
    S0,
    S1,
    S2,
    S3,
    SW,
    S4
  } dma_state_e;

  typedef enum logic [1:0] {
    XferVerify = 2'b00,
    XferWrite  = 2'b01,
    XferRead   = 2'b10
  } xfer_type_e;

  typedef enum logic [1:0] {
    ModeDemand = 2'b00,
    ModeSingle = 2'b01,
    ModeBlock  = 2'b10
  } xfer_mode_e;

  localparam logic StrobeIdle   = 1'b1;
  localparam logic StrobeActive = 1'b0;

  // States in which the channel owns the bus.
  function automatic logic in_transfer(dma_state_e s);
    return s inside {S1, S2, S3, SW, S4};
  endfunction

endpackage

// File: rtl/dma_addr_count.sv
// Base and current address/count registers for one DMA channel.
module dma_addr_count #(
  parameter int unsigned AW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          step_i,
  input  logic          reload_i,
  input  logic          dec_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [AW-1:0] base_count_i,
  output logic [AW-1:0] cur_addr_o,
  output logic          tc_next_o,
  output logic          hi_changed_o
);

  logic [AW-1:0] base_addr_q, base_count_q;
  logic [AW-1:0] cur_addr_q, cur_count_q;
  logic [AW-1:0] addr_next;

  assign addr_next    = dec_i ? cur_addr_q - AW'(1) : cur_addr_q + AW'(1);
  assign hi_changed_o = addr_next[AW-1:8] != cur_addr_q[AW-1:8];
  assign tc_next_o    = cur_count_q == '0;
  assign cur_addr_o   = cur_addr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_addr_q  <= '0;
      base_count_q <= '0;
      cur_addr_q   <= '0;
      cur_count_q  <= '0;
    end else if (load_i) begin
      base_addr_q  <= base_addr_i;
      base_count_q <= base_count_i;
      cur_addr_q   <= base_addr_i;
      cur_count_q  <= base_count_i;
    end else if (reload_i) begin
      // Reload wins over the step of the terminating S4.
      cur_addr_q  <= base_addr_q;
      cur_count_q <= base_count_q;
    end else if (step_i) begin
      cur_addr_q  <= addr_next;
      cur_count_q <= cur_count_q - AW'(1);
    end
  end

endmodule

// File: rtl/dma_cycle_ctrl.sv
// Single-channel 8237A-style transfer-cycle sequencer: HRQ/HLDA handshake, S0-S4 stepping,
// registered strobes and address bytes for the pin datapath.
module dma_cycle_ctrl
  import dma_pkg::*;
#(
  parameter int unsigned AW = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          load,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] base_count,
  input  logic [1:0]    xfer_type,
  input  logic [1:0]    xfer_mode,
  input  logic          autoinit,
  input  logic          addr_dec,
  input  logic          DREQ,
  input  logic          HLDA,
  input  logic          READY,
  input  logic          EOP_N_in,
  output logic          HRQ,
  output logic          DACK,
  output logic          aen,
  output logic          adstb,
  output logic          ior,
  output logic          iow,
  output logic          memr,
  output logic          memw,
  output logic          eop,
  output logic [7:0]    outAddrBuf,
  output logic [7:0]    dbAddrHi,
  output logic          IDLE_CYCLE,
  output logic          ACTIVE_CYCLE,
  output logic          tc_flag
);

  dma_state_e    state_q, state_d, cont_state;
  logic          locked_q, eop_seen_q;
  logic          active, ext_eop, term, load_ok;
  logic          tc_next, hi_changed;
  logic          is_rd, is_wr, lead, trail;
  logic [AW-1:0] cur_addr;

  assign active     = in_transfer(state_q);
  // External EOP seen earlier in this transfer, or right now in S4.
  assign ext_eop    = eop_seen_q | (active & ~EOP_N_in);
  assign term       = (state_q == S4) & (tc_next | ext_eop);
  assign load_ok    = load & ~active & ~ACTIVE_CYCLE;
  assign cont_state = hi_changed ? S1 : S2;

  assign is_rd = xfer_type == XferRead;
  assign is_wr = xfer_type == XferWrite;
  assign lead  = state_q inside {S2, S3, SW, S4};
  assign trail = state_q inside {S3, SW, S4};

  dma_addr_count #(
    .AW(AW)
  ) u_addr_count (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .load_i      (load_ok),
    .step_i      (state_q == S4),
    .reload_i    (term & autoinit),
    .dec_i       (addr_dec),
    .base_addr_i (base_addr),
    .base_count_i(base_count),
    .cur_addr_o  (cur_addr),
    .tc_next_o   (tc_next),
    .hi_changed_o(hi_changed)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SI: if (DREQ && !locked_q) state_d = S0;
      S0: if (HLDA) state_d = S1;
      S1: state_d = S2;
      S2: state_d = S3;
      S3: state_d = READY ? S4 : SW;
      SW: state_d = READY ? S4 : SW;
      S4: begin
        if (term)                                 state_d = SI;
        else if (xfer_mode == ModeBlock)          state_d = cont_state;
        else if (xfer_mode == ModeDemand && DREQ) state_d = cont_state;
        else                                      state_d = SI;
      end
      default: state_d = SI;
    endcase
  end

  // Outputs are decoded from state_q and registered, so they trail the state by one cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= SI;
      locked_q     <= 1'b0;
      eop_seen_q   <= 1'b0;
      tc_flag      <= 1'b0;
      HRQ          <= 1'b0;
      DACK         <= 1'b0;
      aen          <= 1'b0;
      adstb        <= 1'b0;
      ior          <= StrobeIdle;
      iow          <= StrobeIdle;
      memr         <= StrobeIdle;
      memw         <= StrobeIdle;
      eop          <= StrobeIdle;
      outAddrBuf   <= '0;
      dbAddrHi     <= '0;
      IDLE_CYCLE   <= 1'b1;
      ACTIVE_CYCLE <= 1'b0;
    end else begin
      state_q    <= state_d;
      eop_seen_q <= (state_q == S4) ? 1'b0 : ext_eop;
      if (load_ok) begin
        tc_flag  <= 1'b0;
        locked_q <= 1'b0;
      end else if (term) begin
        tc_flag  <= 1'b1;
        locked_q <= ~autoinit;
      end
      HRQ          <= state_q != SI;
      DACK         <= active;
      aen          <= active;
      ACTIVE_CYCLE <= active;
      IDLE_CYCLE   <= ~active;
      adstb        <= state_q == S1;
      memr         <= (is_rd && lead)  ? StrobeActive : StrobeIdle;
      iow          <= (is_rd && trail) ? StrobeActive : StrobeIdle;
      ior          <= (is_wr && lead)  ? StrobeActive : StrobeIdle;
      memw         <= (is_wr && trail) ? StrobeActive : StrobeIdle;
      eop          <= (state_q == S4 && tc_next) ? StrobeActive : StrobeIdle;
      outAddrBuf   <= cur_addr[7:0];
      dbAddrHi     <= cur_addr[15:8];
    end
  end

endmodule

// File: tb/tb_dma_cycle_ctrl.sv
// Bench for dma_cycle_ctrl: a transfer-level model expands each service into the expected
// sequence of bus phases, which is then compared cycle by cycle against the outputs.
module tb_dma_cycle_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        load = 1'b0;
  logic [15:0] base_addr = '0, base_count = '0;
  logic [1:0]  xfer_type = '0, xfer_mode = '0;
  logic        autoinit = 1'b0, addr_dec = 1'b0;
  logic        DREQ = 1'b0, HLDA = 1'b0, READY = 1'b1, EOP_N_in = 1'b1;
  logic        HRQ, DACK, aen, adstb, ior, iow, memr, memw, eop;
  logic [7:0]  outAddrBuf, dbAddrHi;
  logic        IDLE_CYCLE, ACTIVE_CYCLE, tc_flag;

  dma_cycle_ctrl #(.AW(16)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .load        (load),
    .base_addr   (base_addr),
    .base_count  (base_count),
    .xfer_type   (xfer_type),
    .xfer_mode   (xfer_mode),
    .autoinit    (autoinit),
    .addr_dec    (addr_dec),
    .DREQ        (DREQ),
    .HLDA        (HLDA),
    .READY       (READY),
    .EOP_N_in    (EOP_N_in),
    .HRQ         (HRQ),
    .DACK        (DACK),
    .aen         (aen),
    .adstb       (adstb),
    .ior         (ior),
    .iow         (iow),
    .memr        (memr),
    .memw        (memw),
    .eop         (eop),
    .outAddrBuf  (outAddrBuf),
    .dbAddrHi    (dbAddrHi),
    .IDLE_CYCLE  (IDLE_CYCLE),
    .ACTIVE_CYCLE(ACTIVE_CYCLE),
    .tc_flag     (tc_flag)
  );

  always #5 CLK = ~CLK;

  typedef enum {PI, P0, P1, P2, P3, PW, P4} ph_e;
  // One bus cycle: phase shown on the outputs, its address, and the inputs to present
  // while the sequencer is deciding what follows this phase.
  typedef struct {
    ph_e         ph;
    logic [15:0] addr;
    bit          eopx;
    bit          dreq, hlda, ready, eopn;
  } ent_t;

  ent_t        q[$];
  int          checks = 0, errors = 0;
  logic [15:0] m_addr, m_cnt;
  bit          m_locked, m_tcf;
  int          m_xf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void push(ph_e ph, bit eopx, bit dreq, bit hlda, bit ready, bit eopn);
    ent_t e;
    e.ph = ph; e.addr = m_addr; e.eopx = eopx;
    e.dreq = dreq; e.hlda = hlda; e.ready = ready; e.eopn = eopn;
    q.push_back(e);
  endfunction

  // {HRQ,DACK,aen,adstb,ior,iow,memr,memw,eop,IDLE,ACTIVE} expected for a phase.
  function automatic logic [10:0] exp_vec(ent_t e, logic [1:0] ty);
    bit act, first, second, rd, wr;
    act    = e.ph inside {P1, P2, P3, PW, P4};
    first  = e.ph inside {P2, P3, PW, P4};
    second = e.ph inside {P3, PW, P4};
    rd     = ty == 2'b10;
    wr     = ty == 2'b01;
    return {e.ph != PI, act, act, e.ph == P1, !(wr && first), !(rd && second),
            !(rd && first), !(wr && second), !(e.ph == P4 && e.eopx), !act, act};
  endfunction

  task automatic build(input logic [15:0] ba, input logic [15:0] bc, input logic [1:0] md,
                       input bit ai, input bit dc, input int nserv, input int dlen,
                       input int eop_at, input int w0);
    int w, n;
    bit first, hchg, tc, term, cont;
    logic [15:0] nxt;
    q.delete();
    m_addr = ba; m_cnt = bc; m_locked = 0; m_tcf = 0; m_xf = 0; hchg = 0;
    push(PI, 0, 0, 0, 1, 1);
    push(PI, 0, 0, 0, 1, 1);
    for (int s = 0; s < nserv; s++) begin
      q[q.size()-1].dreq = 1'b1;
      if (m_locked) begin
        push(PI, 0, 1, 0, 1, 1);
        push(PI, 0, 1, 0, 1, 1);
        break;
      end
      repeat ($urandom_range(0, 2)) push(P0, 0, 1, 0, 1, 1);
      push(P0, 0, 1, 1, 1, 1);
      first = 1; n = 0;
      forever begin
        if (first || hchg) push(P1, 0, 1, 1, 1, 1);
        push(P2, 0, 1, 1, 1, (m_xf == eop_at) ? 1'b0 : 1'b1);
        w = (m_xf == 0) ? w0 : int'($urandom_range(0, 2));
        push(P3, 0, 1, 1, w == 0, 1);
        for (int k = 0; k < w; k++) push(PW, 0, 1, 1, k == w - 1, 1);
        tc   = m_cnt == 16'h0;
        term = tc || (m_xf == eop_at);
        n++;
        cont = !term && (md == 2'b10 || (md == 2'b00 && n < dlen));
        push(P4, tc, cont, 1, 1, 1);
        nxt  = dc ? m_addr - 16'h1 : m_addr + 16'h1;
        hchg = nxt[15:8] != m_addr[15:8];
        m_addr = nxt; m_cnt = m_cnt - 16'h1; m_xf++; first = 0;
        if (term) begin
          m_tcf = 1;
          if (ai) begin m_addr = ba; m_cnt = bc; end
          else m_locked = 1;
        end
        if (!cont) break;
      end
      push(PI, 0, 0, 0, 1, 1);
    end
    push(PI, 0, 0, 0, 1, 1);
    push(PI, 0, 0, 0, 1, 1);
  endtask

  task automatic run_q(input string tag, input logic [1:0] ty);
    for (int i = 0; i < q.size(); i++) begin
      chk($sformatf("%s[%0d].out", tag, i),
          32'({HRQ, DACK, aen, adstb, ior, iow, memr, memw, eop, IDLE_CYCLE, ACTIVE_CYCLE}),
          32'(exp_vec(q[i], ty)));
      chk($sformatf("%s[%0d].addr", tag, i), 32'({dbAddrHi, outAddrBuf}), 32'(q[i].addr));
      if (i + 1 < q.size()) begin
        DREQ = q[i+1].dreq; HLDA = q[i+1].hlda; READY = q[i+1].ready; EOP_N_in = q[i+1].eopn;
      end else begin
        DREQ = 0; HLDA = 0; READY = 1; EOP_N_in = 1;
      end
      @(posedge CLK); @(negedge CLK);
    end
  endtask

  task automatic scenario(input string tag, input logic [15:0] ba, input logic [15:0] bc,
                          input logic [1:0] ty, input logic [1:0] md, input bit ai,
                          input bit dc, input int nserv, input int dlen, input int eop_at,
                          input int w0);
    xfer_type = ty; xfer_mode = md; autoinit = ai; addr_dec = dc;
    base_addr = ba; base_count = bc; DREQ = 0; HLDA = 0; READY = 1; EOP_N_in = 1;
    load = 1;
    @(posedge CLK); @(negedge CLK);
    load = 0;
    @(posedge CLK); @(negedge CLK);
    chk({tag, ".tc_clear"}, 32'(tc_flag), 32'd0);
    build(ba, bc, md, ai, dc, nserv, dlen, eop_at, w0);
    run_q(tag, ty);
    chk({tag, ".tc_flag"}, 32'(tc_flag), 32'(m_tcf));
  endtask

  initial begin
    logic [7:0] lo;
    bit found;
    repeat (3) @(negedge CLK);
    chk("reset.out", 32'({HRQ, DACK, aen, adstb, ior, iow, memr, memw, eop, IDLE_CYCLE,
        ACTIVE_CYCLE}), 32'(11'b0000_11111_10));
    chk("reset.addr", 32'({dbAddrHi, outAddrBuf}), 32'd0);
    chk("reset.tc", 32'(tc_flag), 32'd0);
    RESET = 0;
    @(negedge CLK);

    scenario("single_rd", 16'h12FF, 16'd1, 2'b10, 2'b01, 0, 0, 3, 1, -1, 0);
    scenario("block_wr", 16'h0040, 16'd3, 2'b01, 2'b10, 0, 0, 1, 1, -1, 2);
    scenario("demand", 16'($urandom), 16'd5, 2'($urandom_range(0, 2)), 2'b00, 0,
             1'($urandom), 3, 2, -1, 0);
    scenario("ext_eop", 16'($urandom), 16'd5, 2'b10, 2'b10, 1, 0, 2, 1, 1, 0);
    for (int r = 0; r < 6; r++) begin
      case ($urandom_range(0, 3))
        0:       lo = 8'hFF;
        1:       lo = 8'h00;
        2:       lo = 8'hFE;
        default: lo = 8'($urandom);
      endcase
      scenario($sformatf("rand%0d", r), {8'($urandom), lo}, 16'($urandom_range(0, 4)),
               2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 1'($urandom),
               1'($urandom), 3, int'($urandom_range(1, 3)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 2)));
    end

    // Asynchronous reset while a read is in S3.
    xfer_type = 2'b10; xfer_mode = 2'b01; autoinit = 0; addr_dec = 0;
    base_addr = 16'h0300; base_count = 16'd2;
    load = 1;
    @(posedge CLK); @(negedge CLK);
    load = 0; DREQ = 1; HLDA = 1; READY = 1; EOP_N_in = 1;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge CLK);
      if (iow === 1'b0) found = 1;
    end
    chk("rst_mid.reach_s3", 32'(found), 32'd1);
    #2 RESET = 1;
    #1 chk("rst_mid.async", 32'({HRQ, aen, ior, iow, memr, memw}), 32'(6'b00_1111));
    DREQ = 0; HLDA = 0;
    @(negedge CLK);
    RESET = 0;
    @(posedge CLK); @(negedge CLK);
    chk("rst_mid.idle", 32'({HRQ, DACK, aen, adstb, ior, iow, memr, memw, eop, IDLE_CYCLE,
        ACTIVE_CYCLE}), 32'(11'b0000_11111_10));
    chk("rst_mid.addr", 32'({dbAddrHi, outAddrBuf}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
